// File: rtl/param_ring_counter_if.sv
// Control and status bundle for the parameterised ring/Johnson counter.
// The master side drives the step/load controls; the slave side is the counter.
interface param_ring_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             mode;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_out;
  logic             wrap;
  logic             illegal;

  modport master (
    output enable, mode, up_down, load, load_value,
    input  count_out, wrap, illegal
  );

  modport slave (
    input  enable, mode, up_down, load, load_value,
    output count_out, wrap, illegal
  );
endinterface

// File: rtl/param_ring_counter.sv
// Ring (one-hot rotate) / Johnson (twisted ring) counter with load,
// direction control, wrap pulse and illegal-state self-correction.
module param_ring_counter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_ring_counter_if.slave  bus
);
  localparam logic             MODE_RING    = 1'b0;
  localparam logic             MODE_JOHNSON = 1'b1;
  localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(1);
  localparam logic [WIDTH-1:0] JOHNSON_SEED = '0;

  logic [WIDTH-1:0] count_reg, count_next;
  logic             mode_reg, mode_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-2:0] trans;
  logic             ring_legal, johnson_legal, illegal;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return (m == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;
  endfunction

  // Adjacent-bit transitions; a legal Johnson state has at most one.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
    assign trans[gi] = count_reg[gi] ^ count_reg[gi+1];
  end

  assign ring_legal    = (count_reg != '0) &&
                         ((count_reg & (count_reg - WIDTH'(1))) == '0);
  assign johnson_legal = ((trans & (trans - (WIDTH-1)'(1))) == '0);
  assign illegal       = (mode_reg == MODE_JOHNSON) ? ~johnson_legal : ~ring_legal;

  always_comb begin
    stepped = count_reg;
    case ({mode_reg, bus.up_down})
      {MODE_RING,    1'b1}: stepped = {count_reg[WIDTH-2:0], count_reg[WIDTH-1]};
      {MODE_RING,    1'b0}: stepped = {count_reg[0], count_reg[WIDTH-1:1]};
      {MODE_JOHNSON, 1'b1}: stepped = {count_reg[WIDTH-2:0], ~count_reg[WIDTH-1]};
      default:              stepped = {~count_reg[0], count_reg[WIDTH-1:1]};
    endcase
  end

  // Priority: load, mode change, self-correction, step, hold.
  always_comb begin
    count_next = count_reg;
    mode_next  = mode_reg;
    wrap_next  = 1'b0;
    if (bus.load) begin
      count_next = bus.load_value;
      mode_next  = bus.mode;
    end else if (bus.mode != mode_reg) begin
      mode_next  = bus.mode;
      count_next = seed_of(bus.mode);
    end else if (bus.enable) begin
      if (illegal) begin
        count_next = seed_of(mode_reg);
      end else begin
        count_next = stepped;
        wrap_next  = (stepped == seed_of(mode_reg));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= RING_SEED;
      mode_reg  <= MODE_RING;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      mode_reg  <= mode_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bus.count_out = count_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.illegal   = illegal;
endmodule

// File: tb/tb_param_ring_counter.sv
// Scoreboard bench for param_ring_counter (WIDTH=4): the driver queues the
// hand-computed response per edge, a negedge monitor pops and compares.
module tb_param_ring_counter;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   txn_id;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [15:0]  id;
    logic [W-1:0] cnt;
    logic         wrap;
    logic         ill;
  } sb_entry_t;

  sb_entry_t sb[$];

  param_ring_counter_if #(.WIDTH(W)) bus ();

  param_ring_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one edge worth of inputs and queue what the DUT must show after it.
  task automatic apply(input logic en, input logic md, input logic ud,
                       input logic ld, input logic [W-1:0] lv,
                       input logic [W-1:0] ecnt, input logic ew, input logic ei);
    sb_entry_t e;
    @(posedge clk);
    #1;
    bus.enable     = en;
    bus.mode       = md;
    bus.up_down    = ud;
    bus.load       = ld;
    bus.load_value = lv;
    e.cyc  = 32'(cyc + 1);
    e.id   = 16'(txn_id);
    e.cnt  = ecnt;
    e.wrap = ew;
    e.ill  = ei;
    txn_id++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].cyc == 32'(cyc)) begin
      e = sb.pop_front();
      $display("txn %0d: count=%b wrap=%b illegal=%b (exp %b %b %b)",
               e.id, bus.count_out, bus.wrap, bus.illegal, e.cnt, e.wrap, e.ill);
      chk($sformatf("txn%0d count", e.id), 32'(bus.count_out), 32'(e.cnt));
      chk($sformatf("txn%0d wrap", e.id), 32'(bus.wrap), 32'(e.wrap));
      chk($sformatf("txn%0d illegal", e.id), 32'(bus.illegal), 32'(e.ill));
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    txn_id = 0;
    rst_n  = 1'b0;
    bus.enable = 1'b0; bus.mode = 1'b0; bus.up_down = 1'b1;
    bus.load = 1'b0;   bus.load_value = '0;
    #12;
    chk("reset count", 32'(bus.count_out), 32'h1);
    chk("reset wrap", 32'(bus.wrap), 32'h0);
    chk("reset illegal", 32'(bus.illegal), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ring up, wrap on return to 0001
    apply(1, 0, 1, 0, 4'h0, 4'b0010, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0100, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b1000, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0001, 1, 0);
    apply(0, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    // Ring down, then direction flip with no latency
    apply(1, 0, 0, 0, 4'h0, 4'b1000, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0001, 1, 0);
    // Mode change beats enable: Johnson seed
    apply(1, 1, 1, 0, 4'h0, 4'b0000, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b0001, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b0011, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b0111, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b1111, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b1110, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b1100, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b1000, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b0000, 1, 0);
    // Johnson down
    apply(1, 1, 0, 0, 4'h0, 4'b1000, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b1100, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b1110, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b1111, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b0111, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b0011, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b0001, 0, 0);
    apply(1, 1, 0, 0, 4'h0, 4'b0000, 1, 0);
    // Ring illegal load, hold, recover (seed reached but no wrap)
    apply(0, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    apply(0, 0, 1, 1, 4'b0110, 4'b0110, 0, 1);
    apply(0, 0, 1, 0, 4'h0, 4'b0110, 0, 1);
    apply(1, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    apply(0, 0, 1, 1, 4'b0000, 4'b0000, 0, 1);
    apply(1, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    // Johnson illegal load (load also switches mode), hold, recover
    apply(0, 1, 1, 1, 4'b0110, 4'b0110, 0, 1);
    apply(0, 1, 1, 0, 4'h0, 4'b0110, 0, 1);
    apply(1, 1, 1, 0, 4'h0, 4'b0000, 0, 0);
    apply(0, 1, 1, 1, 4'b1111, 4'b1111, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b1110, 0, 0);
    // Mode switch at ring 0100 with enable low, then back
    apply(0, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0010, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0100, 0, 0);
    apply(0, 1, 1, 0, 4'h0, 4'b0000, 0, 0);
    apply(0, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0010, 0, 0);
    apply(1, 0, 1, 0, 4'h0, 4'b0100, 0, 0);

    // Asynchronous reset between edges, with load/enable active
    @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b1; bus.load = 1'b1; bus.load_value = 4'b1010; bus.mode = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset count", 32'(bus.count_out), 32'h1);
    chk("async reset wrap", 32'(bus.wrap), 32'h0);
    chk("async reset illegal", 32'(bus.illegal), 32'h0);
    @(posedge clk);
    #1;
    chk("reset held count", 32'(bus.count_out), 32'h1);
    @(negedge clk);
    bus.enable = 1'b0; bus.load = 1'b0;
    rst_n = 1'b1;
    // First Johnson edge after reset loads 0000
    apply(1, 1, 1, 0, 4'h0, 4'b0000, 0, 0);
    apply(1, 1, 1, 0, 4'h0, 4'b0001, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
